// File: rtl/trace_event_arbiter.sv
// Trace event arbiter: per-source one-entry holding slots merged round-robin onto
// the trace buffer write port, with per-source saturating drop counters.
module trace_event_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned EVT_W   = 48,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         clear,
    input  logic [NUM_SRC-1:0]           src_mask,
    input  logic [NUM_SRC-1:0]           src_valid,
    input  logic [NUM_SRC*EVT_W-1:0]     src_event,
    input  logic                         buf_full,
    output logic [63:0]                  trc_data,
    output logic                         trc_write,
    output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
    output logic [NUM_SRC*CNT_W-1:0]     drop_cnt,
    output logic                         overflow
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned SUM_W = IDX_W + 1;
    localparam int unsigned TRC_W = 64;

    logic [NUM_SRC-1:0] slot_full;
    logic [EVT_W-1:0]   slot_data [NUM_SRC];
    logic [IDX_W-1:0]   rr;

    logic               grant_c;
    logic [IDX_W-1:0]   grant_g_c;
    logic [SUM_W-1:0]   scan_idx_c;
    logic [NUM_SRC-1:0] grant_vec_c;
    logic [NUM_SRC-1:0] strobe_c;
    logic [NUM_SRC-1:0] accept_c;
    logic [NUM_SRC-1:0] drop_c;

    // Round-robin scan starting at rr; first full slot wins.
    always_comb begin
        grant_c    = 1'b0;
        grant_g_c  = '0;
        scan_idx_c = '0;
        if (enable && !buf_full) begin
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                scan_idx_c = {1'b0, rr} + SUM_W'(k);
                if (scan_idx_c >= SUM_W'(NUM_SRC)) begin
                    scan_idx_c = scan_idx_c - SUM_W'(NUM_SRC);
                end
                if (!grant_c && slot_full[scan_idx_c[IDX_W-1:0]]) begin
                    grant_c   = 1'b1;
                    grant_g_c = scan_idx_c[IDX_W-1:0];
                end
            end
        end
    end

    // A slot being granted this cycle can accept a new event without dropping.
    always_comb begin
        grant_vec_c = '0;
        strobe_c    = '0;
        accept_c    = '0;
        drop_c      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            grant_vec_c[i] = grant_c && (grant_g_c == IDX_W'(i));
            strobe_c[i]    = enable && src_mask[i] && src_valid[i];
            accept_c[i]    = strobe_c[i] && (!slot_full[i] || grant_vec_c[i]);
            drop_c[i]      = strobe_c[i] && slot_full[i] && !grant_vec_c[i];
        end
    end

    // Control state, output registers and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_full <= '0;
            rr        <= '0;
            trc_write <= 1'b0;
            trc_data  <= '0;
            grant_idx <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            slot_full <= '0;
            rr        <= '0;
            trc_write <= 1'b0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
        end else begin
            trc_write <= grant_c;
            if (grant_c) begin
                trc_data  <= TRC_W'(slot_data[grant_g_c]);
                grant_idx <= grant_g_c;
                rr        <= (grant_g_c == IDX_W'(NUM_SRC - 1)) ? '0 : grant_g_c + IDX_W'(1);
            end
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (accept_c[i]) begin
                    slot_full[i] <= 1'b1;
                end else if (grant_vec_c[i]) begin
                    slot_full[i] <= 1'b0;
                end
                if (drop_c[i] && (drop_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    drop_cnt[i*CNT_W +: CNT_W] <= drop_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
            if (|drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

    // Slot payloads need no reset; validity lives in slot_full.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (accept_c[i] && !clear) begin
                slot_data[i] <= src_event[i*EVT_W +: EVT_W];
            end
        end
    end

endmodule

// File: tb/tb_trace_event_arbiter.sv
// Directed self-checking bench for trace_event_arbiter (4 sources, 4-bit drop counters).
module tb_trace_event_arbiter;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned EVT_W   = 48;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned IDX_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       enable;
    logic                       clear;
    logic [NUM_SRC-1:0]         src_mask;
    logic [NUM_SRC-1:0]         src_valid;
    logic [NUM_SRC*EVT_W-1:0]   src_event;
    logic                       buf_full;
    logic [63:0]                trc_data;
    logic                       trc_write;
    logic [IDX_W-1:0]           grant_idx;
    logic [NUM_SRC*CNT_W-1:0]   drop_cnt;
    logic                       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    trace_event_arbiter #(.NUM_SRC(NUM_SRC), .EVT_W(EVT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .src_mask(src_mask), .src_valid(src_valid), .src_event(src_event),
        .buf_full(buf_full), .trc_data(trc_data), .trc_write(trc_write),
        .grant_idx(grant_idx), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [EVT_W-1:0] evt(input int i, input logic [31:0] d);
        return {8'hA0 + 8'(i), 8'(i), d};
    endfunction

    function automatic logic [CNT_W-1:0] dcnt(input int i);
        return drop_cnt[i*CNT_W +: CNT_W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int i, input logic [EVT_W-1:0] e);
        src_valid[i] = 1'b1;
        src_event[i*EVT_W +: EVT_W] = e;
    endtask

    task automatic do_clear();
        src_valid = '0;
        buf_full  = 1'b0;
        enable    = 1'b1;
        src_mask  = '1;
        clear     = 1'b1;
        step();
        clear     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0; src_mask = '1;
        src_valid = '0; src_event = '0; buf_full = 1'b0;
        #12;
        n_tests++;
        if (trc_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %0b exp 0", trc_write); end
        n_tests++;
        if (trc_data !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", trc_data); end
        n_tests++;
        if (grant_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx: got %0d exp 0", grant_idx); end
        n_tests++;
        if (drop_cnt !== '0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_drop: got cnt %h ovf %0b exp 0 0", drop_cnt, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_event();
        strobe(2, 48'h07_02_DEADBEEF);
        step();
        src_valid = '0;
        n_tests++;
        if (trc_write !== 1'b0) begin n_fail++; $display("FAIL single_early: got %0b exp 0", trc_write); end
        step();
        n_tests++;
        if (trc_write !== 1'b1) begin n_fail++; $display("FAIL single_write: got %0b exp 1", trc_write); end
        n_tests++;
        if (trc_data !== 64'h0000_0702_DEADBEEF) begin
            n_fail++; $display("FAIL single_data: got %h exp 00000702deadbeef", trc_data);
        end
        n_tests++;
        if (grant_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d exp 2", grant_idx); end
        step();
        n_tests++;
        if (trc_write !== 1'b0 || trc_data !== 64'h0000_0702_DEADBEEF) begin
            n_fail++; $display("FAIL single_after: got write %0b data %h exp 0 held", trc_write, trc_data);
        end
    endtask

    task automatic test_fairness();
        int g;
        do_clear();
        for (int k = 1; k <= 24; k++) begin
            if (k <= 20) begin
                for (int i = 0; i < 4; i++) strobe(i, evt(i, 32'h1000_0000 + 32'(i)));
            end else begin
                src_valid = '0;
            end
            step();
            n_tests++;
            if (trc_write !== (k >= 2)) begin
                n_fail++; $display("FAIL fair_write_%0d: got %0b exp %0b", k, trc_write, (k >= 2));
            end
            if (k >= 2) begin
                g = (k - 2) % 4;
                n_tests++;
                if (grant_idx !== 2'(g) || trc_data !== 64'(evt(g, 32'h1000_0000 + 32'(g)))) begin
                    n_fail++;
                    $display("FAIL fair_grant_%0d: got idx %0d data %h exp idx %0d", k, grant_idx, trc_data, g);
                end
            end
            if (k == 20) begin
                n_tests++;
                if (dcnt(0) !== 4'd14 || dcnt(1) !== 4'd14 || dcnt(2) !== 4'd14 || dcnt(3) !== 4'd15) begin
                    n_fail++; $display("FAIL fair_drops: got %h exp f eee (src3..0)", drop_cnt);
                end
                n_tests++;
                if (overflow !== 1'b1) begin n_fail++; $display("FAIL fair_ovf: got %0b exp 1", overflow); end
            end
        end
        step();
        n_tests++;
        if (trc_write !== 1'b0) begin n_fail++; $display("FAIL fair_drained: got %0b exp 0", trc_write); end
    endtask

    task automatic test_backpressure();
        do_clear();
        buf_full = 1'b1;
        strobe(0, evt(0, 32'h0000_00A0));
        strobe(1, evt(1, 32'h0000_00A1));
        for (int c = 0; c < 10; c++) begin
            step();
            src_valid = '0;
            if (c == 1 || c == 3 || c == 5) strobe(0, evt(0, 32'hBAD0_0000 + 32'(c)));
            n_tests++;
            if (trc_write !== 1'b0) begin n_fail++; $display("FAIL bp_blocked_%0d: got %0b exp 0", c, trc_write); end
        end
        n_tests++;
        if (dcnt(0) !== 4'd3 || dcnt(1) !== 4'd0 || overflow !== 1'b1) begin
            n_fail++; $display("FAIL bp_drops: got c0 %0d c1 %0d ovf %0b exp 3 0 1", dcnt(0), dcnt(1), overflow);
        end
        buf_full = 1'b0;
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd0 || trc_data !== 64'(evt(0, 32'h0000_00A0))) begin
            n_fail++; $display("FAIL bp_first: got w %0b idx %0d data %h exp 1 0", trc_write, grant_idx, trc_data);
        end
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd1 || trc_data !== 64'(evt(1, 32'h0000_00A1))) begin
            n_fail++; $display("FAIL bp_second: got w %0b idx %0d data %h exp 1 1", trc_write, grant_idx, trc_data);
        end
        step();
        n_tests++;
        if (trc_write !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %0b exp 0", trc_write); end
    endtask

    task automatic test_back_to_back_refill();
        do_clear();
        strobe(0, evt(0, 32'h0000_0E0A));
        strobe(1, evt(1, 32'h0000_0E1A));
        step();
        src_valid = '0;
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL refill_g0: got w %0b idx %0d exp 1 0", trc_write, grant_idx);
        end
        strobe(1, evt(1, 32'h0000_0E1B));
        step();
        src_valid = '0;
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd1 || trc_data !== 64'(evt(1, 32'h0000_0E1A))) begin
            n_fail++; $display("FAIL refill_old: got w %0b idx %0d data %h exp 1 1 old", trc_write, grant_idx, trc_data);
        end
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd1 || trc_data !== 64'(evt(1, 32'h0000_0E1B))) begin
            n_fail++; $display("FAIL refill_new: got w %0b idx %0d data %h exp 1 1 new", trc_write, grant_idx, trc_data);
        end
        step();
        n_tests++;
        if (trc_write !== 1'b0 || dcnt(1) !== 4'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL refill_nodrop: got w %0b c1 %0d ovf %0b exp 0 0 0", trc_write, dcnt(1), overflow);
        end
    endtask

    task automatic test_saturation_clear();
        do_clear();
        buf_full = 1'b1;
        strobe(3, evt(3, 32'h0000_0333));
        step();
        for (int c = 0; c < 20; c++) begin
            strobe(3, evt(3, 32'hD000_0000 + 32'(c)));
            step();
        end
        src_valid = '0;
        n_tests++;
        if (dcnt(3) !== 4'hF || overflow !== 1'b1) begin
            n_fail++; $display("FAIL sat_cnt: got %h ovf %0b exp f 1", dcnt(3), overflow);
        end
        buf_full = 1'b0;
        clear    = 1'b1;
        strobe(0, evt(0, 32'h0000_0C0C));
        step();
        clear     = 1'b0;
        src_valid = '0;
        n_tests++;
        if (trc_write !== 1'b0 || drop_cnt !== '0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL clear_state: got w %0b cnt %h ovf %0b exp 0 0 0", trc_write, drop_cnt, overflow);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (trc_write !== 1'b0) begin n_fail++; $display("FAIL clear_empty_%0d: got %0b exp 0", c, trc_write); end
        end
    endtask

    task automatic test_mask_enable();
        do_clear();
        src_mask = 4'b1101;
        strobe(1, evt(1, 32'h0000_0111));
        step();
        src_valid = '0;
        for (int c = 0; c < 2; c++) begin
            step();
            n_tests++;
            if (trc_write !== 1'b0) begin n_fail++; $display("FAIL mask_nocap_%0d: got %0b exp 0", c, trc_write); end
        end
        buf_full = 1'b1;
        src_mask = '1;
        strobe(1, evt(1, 32'h0000_0222));
        step();
        src_mask = 4'b1101;
        for (int c = 0; c < 2; c++) begin
            strobe(1, evt(1, 32'h0000_0999));
            step();
        end
        src_valid = '0;
        n_tests++;
        if (dcnt(1) !== 4'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL mask_nocount: got c1 %0d ovf %0b exp 0 0", dcnt(1), overflow);
        end
        buf_full = 1'b0;
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd1 || trc_data !== 64'(evt(1, 32'h0000_0222))) begin
            n_fail++; $display("FAIL mask_pending: got w %0b idx %0d data %h exp 1 1", trc_write, grant_idx, trc_data);
        end

        do_clear();
        for (int i = 0; i < 4; i++) strobe(i, evt(i, 32'h0000_5000 + 32'(i)));
        step();
        src_valid = '0;
        step();
        n_tests++;
        if (trc_write !== 1'b1 || grant_idx !== 2'd0) begin
            n_fail++; $display("FAIL en_first: got w %0b idx %0d exp 1 0", trc_write, grant_idx);
        end
        enable   = 1'b0;
        src_mask = 4'b1011;
        for (int c = 0; c < 4; c++) begin
            strobe(0, evt(0, 32'h0000_6000));
            step();
            n_tests++;
            if (trc_write !== 1'b0) begin n_fail++; $display("FAIL en_off_%0d: got %0b exp 0", c, trc_write); end
        end
        src_valid = '0;
        enable    = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_tests++;
            if (trc_write !== 1'b1 || grant_idx !== 2'(c) || trc_data !== 64'(evt(c, 32'h0000_5000 + 32'(c)))) begin
                n_fail++; $display("FAIL en_resume_%0d: got w %0b idx %0d data %h exp 1 %0d", c, trc_write, grant_idx, trc_data, c);
            end
        end
        step();
        n_tests++;
        if (trc_write !== 1'b0 || dcnt(0) !== 4'd0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL en_nocap: got w %0b c0 %0d ovf %0b exp 0 0 0", trc_write, dcnt(0), overflow);
        end
        src_mask = '1;
    endtask

    task automatic test_reset_mid();
        do_clear();
        strobe(0, evt(0, 32'h0000_7000));
        step();
        src_valid = '0;
        strobe(1, evt(1, 32'h0000_7001));
        step();
        src_valid = '0;
        n_tests++;
        if (trc_write !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %0b exp 1", trc_write); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (trc_write !== 1'b0 || trc_data !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_async: got w %0b data %h exp 0 0", trc_write, trc_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (trc_write !== 1'b0) begin n_fail++; $display("FAIL rstmid_lost_%0d: got %0b exp 0", c, trc_write); end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_fairness();
        test_backpressure();
        test_back_to_back_refill();
        test_saturation_clear();
        test_mask_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
